vxc_chunk_sequencer: RTL

Sequencing controller for the 8-lane vector-times-constant add datapath (`vXc_add_8_delay`). On a `start` pulse it walks both operand vector memories chunk by chunk (NO_OF_UNITS elements per chunk) and zero-pads the tail chunk. For each chunk it launches the datapath, waits for its completion strobe and writes the result chunk to result memory. It replaces ad-hoc per-process counters with one FSM, and adds a watchdog plus a clean finish/busy handshake.

---
 rtl/vxc_pkg.sv | 34 +++
 rtl/vxc_watchdog.sv | 35 +++
 rtl/vxc_chunk_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vxc_pkg.sv
// Shared types and elaboration-time helpers for the vector-times-constant chunk sequencer.
package vxc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT_RD,
    S_LAUNCH,
    S_WAIT_DP,
    S_WR,
    S_DONE
  } state_e;

  localparam int unsigned MAX_LANES = 64;

  function automatic int unsigned num_chunks(input int unsigned neq, input int unsigned units);
    return (neq + units - 1) / units;
  endfunction

  // Lanes actually populated in the tail chunk; a full chunk when neq divides evenly.
  function automatic int unsigned valid_last(input int unsigned neq, input int unsigned units);
    return neq - (num_chunks(neq, units) - 1) * units;
  endfunction

  function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned valid);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      mask[i] = (i < valid);
    end
    return mask;
  endfunction

endpackage

// File: rtl/vxc_watchdog.sv
// Saturating cycle counter; expired flags the TIMEOUT-th cycle counted since the last load.
module vxc_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vxc_chunk_sequencer.sv
// Walks the operand memories chunk by chunk, launches the vXc datapath per chunk and
// writes each result chunk back, with a watchdog on the datapath completion strobe.
module vxc_chunk_sequencer
  import vxc_pkg::*;
#(
  parameter int unsigned NUMBER_OF_EQUATIONS = 16,
  parameter int unsigned NO_OF_UNITS         = 8,
  parameter int unsigned ELEMENT_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH          = 8,
  parameter int unsigned MEM_RD_LAT          = 2,
  parameter int unsigned TIMEOUT             = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 op,
  input  logic [ELEMENT_WIDTH-1:0]             constant,
  output logic                                 busy,
  output logic                                 finish,
  output logic                                 error,
  output logic                                 mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec1_data,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec2_data,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_first_row,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_second_row,
  output logic [ELEMENT_WIDTH-1:0]             dp_constant,
  output logic                                 dp_op,
  output logic                                 dp_start,
  input  logic                                 dp_done,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] dp_result,
  output logic                                 res_we,
  output logic [ADDR_WIDTH-1:0]                res_addr,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] res_data,
  output logic [ADDR_WIDTH-1:0]                chunk_idx
);

  localparam int unsigned W          = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int unsigned NUM_CHUNKS = num_chunks(NUMBER_OF_EQUATIONS, NO_OF_UNITS);
  localparam int unsigned VALID_LAST = valid_last(NUMBER_OF_EQUATIONS, NO_OF_UNITS);
  localparam int unsigned LW         = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [MAX_LANES-1:0] LAST_MASK = lane_mask(VALID_LAST);

  state_e                  state_q, state_d;
  logic [LW-1:0]           lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0]   chunk_q, chunk_d;
  logic                    op_q, op_d;
  logic [ELEMENT_WIDTH-1:0] const_q, const_d;
  logic                    busy_q, busy_d;
  logic                    finish_q, finish_d;
  logic                    error_q, error_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [W-1:0]            row1_q, row1_d;
  logic [W-1:0]            row2_q, row2_d;
  logic                    dp_start_q, dp_start_d;
  logic                    res_we_q, res_we_d;
  logic [ADDR_WIDTH-1:0]   res_addr_q, res_addr_d;
  logic [W-1:0]            res_data_q, res_data_d;
  logic                    wd_load, wd_en, wd_expired, last_chunk;

  vxc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .load    (wd_load),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign last_chunk = (chunk_q == ADDR_WIDTH'(NUM_CHUNKS - 1));

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    chunk_d    = chunk_q;
    op_d       = op_q;
    const_d    = const_q;
    busy_d     = busy_q;
    finish_d   = 1'b0;
    error_d    = error_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    row1_d     = row1_q;
    row2_d     = row2_q;
    dp_start_d = 1'b0;
    res_we_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    wd_load    = 1'b0;
    wd_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          const_d   = constant;
          error_d   = 1'b0;
          chunk_d   = '0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        lat_cnt_d = '0;
        state_d   = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_cnt_q == LW'(MEM_RD_LAT - 1)) begin
          // Tail-chunk lanes beyond the vector length are forced to zero.
          for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
            if (last_chunk && !LAST_MASK[i]) begin
              row1_d[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
              row2_d[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
            end else begin
              row1_d[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = vec1_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
              row2_d[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = vec2_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
          end
          dp_start_d = 1'b1;
          wd_load    = 1'b1;
          state_d    = S_LAUNCH;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_LAUNCH: begin
        wd_en   = 1'b1;
        state_d = S_WAIT_DP;
      end
      S_WAIT_DP: begin
        wd_en = 1'b1;
        if (dp_done) begin
          res_data_d = dp_result;
          res_we_d   = 1'b1;
          res_addr_d = chunk_q;
          state_d    = S_WR;
        end else if (wd_expired) begin
          error_d  = 1'b1;
          finish_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_WR: begin
        if (last_chunk) begin
          finish_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          chunk_d   = chunk_q + ADDR_WIDTH'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = chunk_q + ADDR_WIDTH'(1);
          state_d   = S_RD;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      chunk_q    <= '0;
      op_q       <= 1'b0;
      const_q    <= '0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      error_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      row1_q     <= '0;
      row2_q     <= '0;
      dp_start_q <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      chunk_q    <= chunk_d;
      op_q       <= op_d;
      const_q    <= const_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
      error_q    <= error_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      row1_q     <= row1_d;
      row2_q     <= row2_d;
      dp_start_q <= dp_start_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

  assign busy          = busy_q;
  assign finish        = finish_q;
  assign error         = error_q;
  assign mem_rd_en     = rd_en_q;
  assign mem_rd_addr   = rd_addr_q;
  assign dp_first_row  = row1_q;
  assign dp_second_row = row2_q;
  assign dp_constant   = const_q;
  assign dp_op         = op_q;
  assign dp_start      = dp_start_q;
  assign res_we        = res_we_q;
  assign res_addr      = res_addr_q;
  assign res_data      = res_data_q;
  assign chunk_idx     = chunk_q;

endmodule
